mux2_rr_arbiter: RTL and testbench
==================================

Name: mux2_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 2:1 data mux between two valid/ready streaming requesters, producing a single downstream stream.
- Grants one requester for a burst: ends on last, on MAX_BURST beats, or on an idle timeout.
- Drives the registered mux select and gates the valid/ready handshakes.
- Sits between two producer blocks and a single shared consumer.

Parameters:
- DW, 8, data width of each input and the output.
- MAX_BURST, 4, maximum accepted beats per grant (>=1).
- IDLE_TIMEOUT, 8, consecutive cycles the granted requester may hold valid low before its grant is revoked (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- in0_valid  input  1  requester 0 has a beat.
- in0_data  input  DW  requester 0 data.
- in0_last  input  1  requester 0 final beat of packet.
- in0_ready  output  1  beat from requester 0 accepted this cycle.
- in1_valid  input  1  requester 1 has a beat.
- in1_data  input  DW  requester 1 data.
- in1_last  input  1  requester 1 final beat of packet.
- in1_ready  output  1  beat from requester 1 accepted this cycle.
- out_valid  output  1  downstream beat valid.
- out_data  output  DW  muxed data, equal to sel ? in1_data : in0_data.
- out_last  output  1  muxed last, equal to sel ? in1_last : in0_last.
- out_ready  input  1  downstream accepts beat.
- sel  output  1  registered mux select, i.e. current or most recent grant.
- busy  output  1  high while in a GRANT state.

Behaviour:
- States: IDLE, GRANT0, GRANT1. Registers: state, sel, prio (the channel to favour on a tie), beat_cnt (clog2(MAX_BURST) bits, minimum 1), idle_cnt (clog2(IDLE_TIMEOUT+1) bits).
- Reset (rst_n low at an edge): state=IDLE, sel=0, prio=0, beat_cnt=0, idle_cnt=0. Outputs settle to out_valid=0, in0_ready=0, in1_ready=0, busy=0. Reset overrides a burst in progress; an in-flight beat that cycle is not accepted.
- Combinational handshake:
  - out_valid = busy & (sel ? in1_valid : in0_valid).
  - inX_ready = out_ready & busy & (sel==X).
  - beat = out_valid & out_ready.
- IDLE:
  - If exactly one inX_valid is high, go to GRANTX and set sel=X.
  - If both are high, grant the channel equal to prio.
  - If neither is high, stay in IDLE.
  - Arbitration latency: first beat can be accepted one cycle after the valid is first seen in IDLE.
- GRANTX, each cycle:
  - beat: beat_cnt increments and idle_cnt clears.
  - Granted valid low: idle_cnt increments.
  - Granted valid high with no beat (backpressure): idle_cnt clears; backpressure never causes a timeout.
- Release conditions:
  - (a) beat with out_last=1.
  - (b) beat while beat_cnt==MAX_BURST-1.
  - (c) idle_cnt==IDLE_TIMEOUT-1 while the granted valid is low.
- On release:
  - beat_cnt and idle_cnt clear and prio becomes ~X.
  - If the other channel's valid is high that same cycle, go directly to GRANT(~X) with sel=~X, with no bubble.
  - Otherwise go to IDLE; sel holds X.
- The non-granted requester always sees ready=0, and its valid/data are ignored.
- Requesters must hold valid/data/last stable until ready; the arbiter does not check this.
- MAX_BURST=1: every beat releases.
- Simultaneous conditions (a) and (b) count as a single release.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with both valids high -> out_valid=0, both readies 0, sel=0, busy=0. After release, GRANT0 on the next edge (prio=0).
- Single requester: in1 sends 3 beats with last on beat 3, out_ready=1 -> grant one cycle after valid, sel=1. out_data follows in1_data, in1_ready is high for exactly 3 cycles, then IDLE with busy=0.
- Burst cap: in0 valid continuously with no last, in1 valid, MAX_BURST=4 -> exactly 4 beats from in0, then sel=1 on the next cycle with no idle cycle. Grants alternate 0,1,0,1 in groups of 4.
- Fairness tie: both valid in IDLE after a channel-0 burst -> channel 1 granted.
- Backpressure: out_ready=0 for 20 cycles mid-burst with the granted valid high -> grant held, no timeout, beat_cnt unchanged. The burst resumes when out_ready=1.
- Timeout: the granted requester drops valid for IDLE_TIMEOUT=8 cycles -> release after the 8th low cycle. Switch to the other channel if it is valid, else go to IDLE. Asserting rst_n=0 mid-burst returns to IDLE next edge with sel=0.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter that shares one 2:1 data mux between two valid/ready
// requesters. A grant lasts until last, MAX_BURST beats, or an idle timeout.
module mux2_rr_arbiter #(
  parameter int DW           = 8,
  parameter int MAX_BURST    = 4,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in0_valid,
  input  logic [DW-1:0] in0_data,
  input  logic          in0_last,
  output logic          in0_ready,
  input  logic          in1_valid,
  input  logic [DW-1:0] in1_data,
  input  logic          in1_last,
  output logic          in1_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          sel,
  output logic          busy
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic          sel_q, sel_d;
  logic          prio_q, prio_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;

  logic grant_valid;
  logic other_valid;
  logic beat;
  logic release_grant;
  logic pick;

  // Handshake: a beat transfers when out_valid and out_ready are both high;
  // only the granted requester ever sees ready, the other is held off.
  assign busy        = (state_q != ST_IDLE);
  assign sel         = sel_q;
  assign grant_valid = sel_q ? in1_valid : in0_valid;
  assign other_valid = sel_q ? in0_valid : in1_valid;
  assign out_data    = sel_q ? in1_data : in0_data;
  assign out_last    = sel_q ? in1_last : in0_last;
  assign out_valid   = busy & grant_valid;
  assign in0_ready   = out_ready & busy & ~sel_q;
  assign in1_ready   = out_ready & busy & sel_q;
  assign beat        = out_valid & out_ready;

  assign release_grant = busy &
                         ((beat & (out_last | (beat_cnt_q == BEAT_LAST))) |
                          (~grant_valid & (idle_cnt_q == IDLE_LAST)));

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    prio_d     = prio_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    pick       = (in0_valid & in1_valid) ? prio_q : in1_valid;
    case (state_q)
      ST_IDLE: begin
        if (in0_valid | in1_valid) begin
          sel_d   = pick;
          state_d = pick ? ST_GRANT1 : ST_GRANT0;
        end
      end
      default: begin
        if (release_grant) begin
          beat_cnt_d = '0;
          idle_cnt_d = '0;
          prio_d     = ~sel_q;
          // Hand straight over to a waiting peer so the mux never bubbles.
          if (other_valid) begin
            sel_d   = ~sel_q;
            state_d = sel_q ? ST_GRANT0 : ST_GRANT1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          idle_cnt_d = '0;
        end else if (!grant_valid) begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end else begin
          idle_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= 1'b0;
      prio_q     <= 1'b0;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      prio_q     <= prio_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: vector table, directed corner
// sequences and randomized traffic against a grant-level reference model.
module tb_mux2_rr_arbiter;

  localparam int DW           = 8;
  localparam int MAX_BURST    = 4;
  localparam int IDLE_TIMEOUT = 8;

  logic          clk;
  logic          rst_n;
  logic          in0_valid, in0_last, in0_ready;
  logic [DW-1:0] in0_data;
  logic          in1_valid, in1_last, in1_ready;
  logic [DW-1:0] in1_data;
  logic          out_valid, out_last, out_ready;
  logic [DW-1:0] out_data;
  logic          sel, busy;

  mux2_rr_arbiter #(.DW(DW), .MAX_BURST(MAX_BURST), .IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (grant-level) ----------------
  int m_owner;    // -1 when nobody holds the mux
  int m_last_ch;  // channel of the current or most recent grant
  int m_favour;   // channel that wins a tie
  int m_beats;    // beats accepted in the current grant
  int m_quiet;    // consecutive granted-valid-low cycles

  logic [DW:0] exp_q[$];   // {last, data} of beats the model expects downstream
  logic        beat_ch_q[$];

  logic s_ov, s_r0, s_r1, s_sel, s_busy, s_last;
  logic [DW-1:0] s_data;

  task automatic model_reset();
    m_owner = -1; m_last_ch = 0; m_favour = 0; m_beats = 0; m_quiet = 0;
  endtask

  task automatic model_update(input logic rn, input logic v0, input logic l0,
                              input logic v1, input logic l1, input logic ordy);
    logic gv, lst, peer, done;
    int other;
    if (!rn) begin
      model_reset();
    end else if (m_owner < 0) begin
      if (v0 && v1) m_owner = m_favour;
      else if (v0)  m_owner = 0;
      else if (v1)  m_owner = 1;
      if (m_owner >= 0) m_last_ch = m_owner;
    end else begin
      gv   = (m_owner == 1) ? v1 : v0;
      lst  = (m_owner == 1) ? l1 : l0;
      peer = (m_owner == 1) ? v0 : v1;
      done = 1'b0;
      if (gv && ordy) begin
        m_beats++;
        m_quiet = 0;
        if (lst || m_beats == MAX_BURST) done = 1'b1;
      end else if (!gv) begin
        m_quiet++;
        if (m_quiet == IDLE_TIMEOUT) done = 1'b1;
      end else begin
        m_quiet = 0;
      end
      if (done) begin
        other    = 1 - m_owner;
        m_favour = other;
        m_beats  = 0;
        m_quiet  = 0;
        if (peer) begin
          m_owner   = other;
          m_last_ch = other;
        end else begin
          m_owner = -1;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic rn, input logic v0, input logic [DW-1:0] d0, input logic l0,
                       input logic v1, input logic [DW-1:0] d1, input logic l1, input logic ordy);
    rst_n = rn; in0_valid = v0; in0_data = d0; in0_last = l0;
    in1_valid = v1; in1_data = d1; in1_last = l1; out_ready = ordy;
  endtask

  task automatic sample();
    s_ov = out_valid; s_r0 = in0_ready; s_r1 = in1_ready; s_sel = sel;
    s_busy = busy; s_data = out_data; s_last = out_last;
  endtask

  // One cycle: drive, compare at the falling edge against the model, advance.
  task automatic step(input logic rn, input logic v0, input logic [DW-1:0] d0, input logic l0,
                      input logic v1, input logic [DW-1:0] d1, input logic l1, input logic ordy);
    logic e_busy, e_sel, e_ov;
    logic [DW:0] sb;
    drive(rn, v0, d0, l0, v1, d1, l1, ordy);
    #4;
    sample();
    e_busy = (m_owner >= 0);
    e_sel  = (m_last_ch == 1);
    e_ov   = e_busy && (e_sel ? v1 : v0);
    check_bit("busy", s_busy, e_busy);
    check_bit("sel", s_sel, e_sel);
    check_bit("out_valid", s_ov, e_ov);
    check_bit("in0_ready", s_r0, ordy && e_busy && !e_sel);
    check_bit("in1_ready", s_r1, ordy && e_busy && e_sel);
    check_data("out_data", s_data, e_sel ? d1 : d0);
    check_bit("out_last", s_last, e_sel ? l1 : l0);
    if (rn && e_ov && ordy) exp_q.push_back(e_sel ? {l1, d1} : {l0, d0});
    if (rn && s_ov && ordy) begin
      beat_ch_q.push_back(s_sel);
      check_int("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        sb = exp_q.pop_front();
        check_data("sb_data", s_data, sb[DW-1:0]);
        check_bit("sb_last", s_last, sb[DW]);
      end
    end
    @(posedge clk);
    model_update(rn, v0, l0, v1, l1, ordy);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    model_reset();
    exp_q.delete();
    beat_ch_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic rn; logic v0; logic [DW-1:0] d0; logic l0;
    logic v1; logic [DW-1:0] d1; logic l1; logic ordy;
    logic e_ov; logic e_r0; logic e_r1; logic e_sel; logic e_busy; logic [DW-1:0] e_data;
  } vec_t;

  vec_t vecs[9];

  int cnt;
  logic rv0, rl0, rv1, rl1, rrn, rordy;
  logic [DW-1:0] rd0, rd1;
  int pv;

  initial begin
    //             rn    v0    d0     l0    v1    d1     l1    ordy  ov    r0    r1    sel   busy  data
    vecs[0] = '{1'b0, 1'b1, 8'hA0, 1'b0, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA0};
    vecs[1] = '{1'b0, 1'b1, 8'hA0, 1'b0, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA0};
    vecs[2] = '{1'b0, 1'b1, 8'hA0, 1'b0, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA0};
    vecs[3] = '{1'b1, 1'b1, 8'hA0, 1'b0, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA0};
    vecs[4] = '{1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1};
    vecs[5] = '{1'b1, 1'b1, 8'hA2, 1'b1, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA2};
    vecs[6] = '{1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB2};
    vecs[7] = '{1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 8'hB3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB3};
    vecs[8] = '{1'b1, 1'b0, 8'hA4, 1'b0, 1'b1, 8'hB4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA4};

    s_r0 = 1'b0; s_r1 = 1'b0;
    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].rn, vecs[i].v0, vecs[i].d0, vecs[i].l0,
            vecs[i].v1, vecs[i].d1, vecs[i].l1, vecs[i].ordy);
      #4;
      sample();
      check_bit("tbl_out_valid", s_ov, vecs[i].e_ov);
      check_bit("tbl_in0_ready", s_r0, vecs[i].e_r0);
      check_bit("tbl_in1_ready", s_r1, vecs[i].e_r1);
      check_bit("tbl_sel", s_sel, vecs[i].e_sel);
      check_bit("tbl_busy", s_busy, vecs[i].e_busy);
      check_data("tbl_out_data", s_data, vecs[i].e_data);
      @(posedge clk);
      #1;
    end

    // Burst cap: both always valid, no last -> groups of 4 alternating, no bubbles.
    do_reset();
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, DW'(8'h10 + i), 1'b0, 1'b1, DW'(8'h80 + i), 1'b0, 1'b1);
    check_int("cap_beats", beat_ch_q.size(), 19);
    if (beat_ch_q.size() >= 16)
      for (int k = 0; k < 16; k++)
        check_int("cap_channel", int'(beat_ch_q[k]), (k / 4) % 2);

    // Fairness tie after a channel-0 burst.
    do_reset();
    step(1'b1, 1'b1, 8'h31, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'h31, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'h32, 1'b0, 1'b1, 8'h41, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'h32, 1'b0, 1'b1, 8'h41, 1'b0, 1'b1);
    check_bit("tie_sel", s_sel, 1'b1);
    check_bit("tie_busy", s_busy, 1'b1);

    // Backpressure: 20 stalled cycles mid-burst, then the burst finishes its 4 beats.
    do_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h51, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h51, 1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h52, 1'b0, 1'b0);
      if (s_busy && s_sel) cnt++;
    end
    check_int("bp_held", cnt, 20);
    check_int("bp_beats_so_far", beat_ch_q.size(), 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, DW'(8'h60 + i), 1'b0, 1'b1);
      if (!s_busy) break;
      if (s_ov) cnt++;
    end
    check_int("bp_resume_beats", cnt, MAX_BURST - 1);
    check_bit("bp_released", s_busy, 1'b0);

    // Timeout to IDLE: released after the 8th low cycle.
    do_reset();
    step(1'b1, 1'b1, 8'h21, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 8'h23, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      if (s_busy) cnt++;
      else break;
    end
    check_int("timeout_cycles", cnt, IDLE_TIMEOUT);
    check_bit("timeout_idle", s_busy, 1'b0);

    // Timeout with the peer waiting switches directly to it.
    do_reset();
    step(1'b1, 1'b1, 8'h24, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < IDLE_TIMEOUT; i++)
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h71, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h71, 1'b0, 1'b1);
    check_bit("timeout_switch_sel", s_sel, 1'b1);
    check_bit("timeout_switch_busy", s_busy, 1'b1);

    // Reset mid-burst while channel 1 holds the grant.
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h72, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check_bit("rst_mid_busy", s_busy, 1'b0);
    check_bit("rst_mid_sel", s_sel, 1'b0);

    // Randomized traffic; requesters hold a beat until it is accepted.
    rv0 = 1'b0; rv1 = 1'b0; rl0 = 1'b0; rl1 = 1'b0; rd0 = '0; rd1 = '0;
    for (int i = 0; i < 3000; i++) begin
      pv = ((i / 400) % 2 == 0) ? 80 : 20;
      if (!rv0 || s_r0) begin
        rv0 = ($urandom_range(0, 99) < pv);
        rd0 = DW'($urandom);
        rl0 = ($urandom_range(0, 3) == 0);
      end
      if (!rv1 || s_r1) begin
        rv1 = ($urandom_range(0, 99) < pv);
        rd1 = DW'($urandom);
        rl1 = ($urandom_range(0, 3) == 0);
      end
      rrn   = ($urandom_range(0, 249) != 0);
      rordy = ($urandom_range(0, 3) != 0);
      step(rrn, rv0, rd0, rl0, rv1, rd1, rl1, rordy);
    end
    check_int("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
